// File: rtl/if_fetch_if.sv
// if_fetch_if: handshake bundle between the fetch stage, instruction memory and IF/ID.
interface if_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:2] redirect_pc;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:2] fourPC;
  logic [31:0] instruction;
  logic        valid;
  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, fourPC, instruction, valid
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, fourPC, instruction, valid
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a one-entry skid buffer and redirect flush.
module if_fetch #(
  parameter logic [31:2] RESET_PC = 30'h0000_0C00
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;
  state_t      r_state, w_state;
  logic [31:2] r_pc, w_pc;
  logic [31:2] r_pend, w_pend;
  logic [31:0] r_skid_instr, w_skid_instr;
  logic [31:2] r_skid_fpc, w_skid_fpc;
  logic [31:0] r_instr, w_instr;
  logic [31:2] r_fpc, w_fpc;
  logic        r_valid, w_valid;
  logic [31:2] w_pc_inc;
  assign w_pc_inc = r_pc + 30'd1;
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_pend       = r_pend;
    w_skid_instr = r_skid_instr;
    w_skid_fpc   = r_skid_fpc;
    w_instr      = r_instr;
    w_fpc        = r_fpc;
    w_valid      = r_valid;
    unique case (r_state)
      FETCH: begin
        if (bus.redirect) begin
          w_valid = 1'b0;
          if (bus.imem_ack) w_pc = bus.redirect_pc;
          else begin
            w_pend  = bus.redirect_pc;
            w_state = KILL;
          end
        end else if (bus.imem_ack) begin
          w_pc = w_pc_inc;
          // Downstream is holding a live instruction: park the new one in the skid.
          if (r_valid && bus.stall) begin
            w_skid_instr = bus.imem_rdata;
            w_skid_fpc   = w_pc_inc;
            w_state      = HOLD;
          end else begin
            w_instr = bus.imem_rdata;
            w_fpc   = w_pc_inc;
            w_valid = 1'b1;
          end
        end else w_valid = r_valid && bus.stall;
      end
      HOLD: begin
        if (bus.redirect) begin
          w_valid      = 1'b0;
          w_pc         = bus.redirect_pc;
          w_skid_instr = '0;
          w_skid_fpc   = '0;
          w_state      = FETCH;
        end else if (!bus.stall) begin
          w_instr = r_skid_instr;
          w_fpc   = r_skid_fpc;
          w_valid = 1'b1;
          w_state = FETCH;
        end
      end
      KILL: begin
        // The outstanding request must complete before the new target is fetched.
        if (bus.imem_ack) begin
          w_pc    = bus.redirect ? bus.redirect_pc : r_pend;
          w_state = FETCH;
        end else if (bus.redirect) w_pend = bus.redirect_pc;
      end
      default: w_state = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_pend       <= '0;
      r_skid_instr <= '0;
      r_skid_fpc   <= '0;
      r_instr      <= '0;
      r_fpc        <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_pend       <= w_pend;
      r_skid_instr <= w_skid_instr;
      r_skid_fpc   <= w_skid_fpc;
      r_instr      <= w_instr;
      r_fpc        <= w_fpc;
      r_valid      <= w_valid;
    end
  end
  assign bus.imem_req    = rst && (r_state != HOLD);
  assign bus.imem_addr   = r_pc;
  assign bus.fourPC      = r_fpc;
  assign bus.instruction = r_instr;
  assign bus.valid       = r_valid;
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 30'h0000_0C00 (byte address 0x3000), word address loaded into the PC at reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  downstream (IF/ID) hold; valid output must not change while 1.
REQ-005 redirect  input  1  branch/jump flush; has priority over stall.
REQ-006 redirect_pc  input  [31:2]  word-address target, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  [31:2]  word address of the request.
REQ-009 imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  [31:0]  fetched instruction word.
REQ-011 fourPC  output  [31:2]  registered PC+4 (word address +1) of the presented instruction.
REQ-012 instruction  output  [31:0]  registered fetched instruction.
REQ-013 valid  output  1  fourPC/instruction hold a live instruction.

Function
REQ-014 Internal state: pc [31:2] (next fetch address), skid buffer (instr, fourPC), pend [31:2], FSM {FETCH, HOLD, KILL}.
REQ-015 Memory protocol: once imem_req=1, imem_req and imem_addr remain stable until the cycle imem_ack=1; imem_ack without imem_req is ignored.
REQ-016 imem_req = 1 in FETCH and KILL, 0 in HOLD and while rst=0; imem_addr = pc in FETCH, the outstanding address in KILL.
REQ-017 FETCH, ack, no redirect, (!valid or !stall): instruction<=imem_rdata, fourPC<=pc+1, valid<=1, pc<=pc+1; stay FETCH (back-to-back fetch, 1 result per cycle with zero-wait memory).
REQ-018 FETCH, ack, no redirect, valid and stall: skid<=(imem_rdata, pc+1), pc<=pc+1, outputs hold, go HOLD.
REQ-019 FETCH, no ack, no redirect: outputs hold if valid and stall; otherwise, if !stall, valid<=0 (presented instruction consumed).
REQ-020 HOLD: outputs hold while stall=1; when stall=0, outputs<=skid, valid<=1, go FETCH.
REQ-021 Redirect in FETCH with ack in the same cycle: discard imem_rdata, valid<=0, pc<=redirect_pc, stay FETCH.
REQ-022 Redirect in FETCH without ack: valid<=0, pend<=redirect_pc, go KILL.
REQ-023 Redirect in HOLD: skid discarded, valid<=0, pc<=redirect_pc, go FETCH.
REQ-024 KILL: valid=0; a further redirect overwrites pend (last wins); on ack, discard data, pc<=pend (or redirect_pc if redirect is asserted that cycle), go FETCH.
REQ-025 Arithmetic: pc+1 is 30-bit modulo; 30'h3FFF_FFFF wraps to 30'h0000_0000, with no flag.
REQ-026 stall while valid=0 has no effect; the output register loads freely.
REQ-027 Latency: request issue to output valid = ack cycle + 1 edge.

Reset
REQ-028 rst=0 asynchronously forces pc=RESET_PC, FSM=FETCH, valid=0, instruction=0, fourPC=0, skid and pend=0, and imem_req=0 combinationally.
REQ-029 Reset mid-transaction (any state) abandons the outstanding request; the memory side must tolerate the dropped request.
REQ-030 First request (imem_addr=RESET_PC) is issued in the first cycle after rst rises.

Verification
REQ-031 Reset release, zero-wait memory (ack whenever req): consecutive outputs fourPC=C01,C02,C03 with instruction=mem[C00..C02] and valid=1 from edge 1.
REQ-032 Acks delayed 3 cycles: imem_addr stays C00 for 3 cycles, no output change, valid pulses 1 after each ack edge.
REQ-033 valid=1 showing A, stall=1 for 4 cycles, ack for B arrives in cycle 2: outputs stay A, imem_req=0 from cycle 3; stall falls, next edge shows B, and req resumes at B's pc+1.
REQ-034 Outstanding req at C05 unacked, redirect to 30'h0040: valid=0 next edge, imem_addr stays C05 until ack, data discarded, next req addr=0040.
REQ-035 Redirect to 0x0080 in the same cycle as ack and stall: output not loaded, valid=0, next req addr=0080; redirect in HOLD clears skid.
REQ-036 pc=30'h3FFF_FFFF fetched: fourPC=0, next req addr=0; rst pulsed low during KILL: req=0 and valid=0 immediately, then fetch from C00.
